// File: rtl/mm_pkg.sv
// mm_pkg: shared types and helpers for mm_bram_adapter.
// FSM state enum, parameter legality check, address shift.
package mm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    DRAIN,
    DONE
  } mm_state_e;

  function automatic bit mm_params_ok(
    input int bw,
    input int lw,
    input int rl
  );
    return ((bw == 32) || (bw == 64)) &&
           (lw >= 1) && (lw <= bw) &&
           ((rl == 1) || (rl == 2));
  endfunction

  // Word address to byte address: log2(bytes per BRAM word).
  function automatic int mm_addr_shift(input int bw);
    return (bw == 64) ? 3 : 2;
  endfunction

endpackage

// File: rtl/mm_rd_valid_pipe.sv
// mm_rd_valid_pipe: LATENCY-deep read-valid token shift register.
// i_token in, o_valid after LATENCY cycles, o_pending = token in an earlier stage.
module mm_rd_valid_pipe
  import mm_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_token,
  output logic o_valid,
  output logic o_pending
);

  logic [LATENCY-1:0] r_tok;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tok <= '0;
    end else begin
      r_tok[0] <= i_token;
      for (int k = 1; k < LATENCY; k++) begin
        r_tok[k] <= r_tok[k-1];
      end
    end
  end

  assign o_valid = r_tok[LATENCY-1];

  // A token in the last stage is being delivered this cycle,
  // so only the stages before it still count as in flight.
  always_comb begin
    o_pending = 1'b0;
    for (int k = 0; k < LATENCY - 1; k++) begin
      o_pending = o_pending | r_tok[k];
    end
  end

endmodule

// File: rtl/mm_bram_adapter.sv
// mm_bram_adapter: run control for a multiplier core plus its BRAM master.
// Host: start_i/done_o/busy_o/cycle_count_o. Core: core_* word requests,
// core_dout_o/core_dout_valid_o. BRAM: BRAM_* byte-addressed master port.
module mm_bram_adapter
  import mm_pkg::*;
#(
  parameter int          BRAM_WIDTH   = 32,
  parameter int          LIMB_WIDTH   = 17,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] ADDR_BASE    = 32'h0
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  output logic                    done_o,
  output logic                    busy_o,
  output logic [31:0]             cycle_count_o,
  output logic                    core_start_o,
  input  logic                    core_done_i,
  input  logic [31:0]             core_addr_i,
  input  logic                    core_en_i,
  input  logic                    core_we_i,
  input  logic [LIMB_WIDTH-1:0]   core_din_i,
  output logic [LIMB_WIDTH-1:0]   core_dout_o,
  output logic                    core_dout_valid_o,
  input  logic [BRAM_WIDTH-1:0]   BRAM_dout_i,
  output logic [BRAM_WIDTH-1:0]   BRAM_din_o,
  output logic [BRAM_WIDTH/8-1:0] BRAM_we_o,
  output logic [31:0]             BRAM_addr_o,
  output logic                    BRAM_clock_o,
  output logic                    BRAM_reset_o,
  output logic                    BRAM_en_o
);

  localparam int ShiftC = mm_addr_shift(BRAM_WIDTH);
  localparam int WeW    = BRAM_WIDTH / 8;

  if (!mm_params_ok(BRAM_WIDTH, LIMB_WIDTH, READ_LATENCY)) begin : g_bad_params
    $error("mm_bram_adapter: illegal BRAM_WIDTH/LIMB_WIDTH/READ_LATENCY");
  end

  mm_state_e              r_state;
  mm_state_e              w_next;
  logic                   w_busy;
  logic                   w_start_acc;
  logic                   w_en;
  logic                   w_rd;
  logic                   w_valid;
  logic                   w_pending;
  logic                   r_done;
  logic [31:0]            r_count;
  logic [LIMB_WIDTH-1:0]  r_hold;
  logic                   w_unused_dout;

  assign w_busy = (r_state == LAUNCH) ||
                  (r_state == RUN) ||
                  (r_state == DRAIN);

  assign w_start_acc = (r_state == IDLE) && start_i;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start_i) w_next = LAUNCH;
      end
      LAUNCH: begin
        w_next = RUN;
      end
      RUN: begin
        if (core_done_i) w_next = DRAIN;
      end
      DRAIN: begin
        // A read issued in DRAIN itself also holds us here.
        if (!w_pending && !w_rd) w_next = DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_done <= 1'b0;
    end else if (w_start_acc) begin
      r_done <= 1'b0;
    end else if (w_next == DONE) begin
      r_done <= 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_count <= '0;
    end else if (w_start_acc) begin
      r_count <= '0;
    end else if (w_busy && (r_count != '1)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign w_en = core_en_i & w_busy;
  assign w_rd = w_en & ~core_we_i;

  mm_rd_valid_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .i_clk     (clock_i),
    .i_rst     (reset_i),
    .i_token   (w_rd),
    .o_valid   (w_valid),
    .o_pending (w_pending)
  );

  // BRAM data is only stable on the valid cycle; keep a copy after it.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_hold <= '0;
    end else if (w_valid) begin
      r_hold <= BRAM_dout_i[LIMB_WIDTH-1:0];
    end
  end

  assign core_dout_o = w_valid ? BRAM_dout_i[LIMB_WIDTH-1:0] : r_hold;
  assign core_dout_valid_o = w_valid;

  assign w_unused_dout = ^BRAM_dout_i;

  assign done_o        = r_done;
  assign busy_o        = w_busy;
  assign cycle_count_o = r_count;
  assign core_start_o  = (r_state == LAUNCH);

  assign BRAM_en_o    = w_en;
  assign BRAM_we_o    = {WeW{w_en & core_we_i}};
  assign BRAM_addr_o  = ADDR_BASE + (core_addr_i << ShiftC);
  assign BRAM_din_o   = BRAM_WIDTH'(core_din_i);
  assign BRAM_clock_o = clock_i;
  assign BRAM_reset_o = reset_i;

endmodule

// File: tb/tb_mm_bram_adapter.sv
// tb_mm_bram_adapter: two adapter configs, each with a BRAM model,
// a reference model checked every cycle, and directed literal checks.
module tb_mm_bram_adapter;

  localparam int LW = 17;

  logic clk = 1'b0;
  logic rst;
  logic chk_on;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic          st  [2];
  logic          cd  [2];
  logic          cen [2];
  logic          cwe [2];
  logic [31:0]   cad [2];
  logic [LW-1:0] cdi [2];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int          BW   = (g == 1) ? 64 : 32;
    localparam int          RL   = (g == 1) ? 2 : 1;
    localparam int          SH   = (g == 1) ? 3 : 2;
    localparam logic [31:0] BASE = (g == 1) ? 32'h100 : 32'h0;

    logic [BW-1:0]   bdout, bdin;
    logic [BW/8-1:0] bwe;
    logic            bclk, brst, ben, done, busy, cs, dv;
    logic [31:0]     cnt, baddr;
    logic [LW-1:0]   dout;

    mm_bram_adapter #(
      .BRAM_WIDTH(BW), .LIMB_WIDTH(LW),
      .READ_LATENCY(RL), .ADDR_BASE(BASE)
    ) u_dut (
      .clock_i(clk), .reset_i(rst), .start_i(st[g]),
      .done_o(done), .busy_o(busy), .cycle_count_o(cnt),
      .core_start_o(cs), .core_done_i(cd[g]),
      .core_addr_i(cad[g]), .core_en_i(cen[g]), .core_we_i(cwe[g]),
      .core_din_i(cdi[g]), .core_dout_o(dout), .core_dout_valid_o(dv),
      .BRAM_dout_i(bdout), .BRAM_din_o(bdin), .BRAM_we_o(bwe),
      .BRAM_addr_o(baddr), .BRAM_clock_o(bclk), .BRAM_reset_o(brst),
      .BRAM_en_o(ben)
    );

    // BRAM model driven by the DUT's master port.
    logic [BW-1:0] mem [64];
    logic [BW-1:0] rp  [RL];
    logic [5:0]    widx;

    initial begin
      for (int i = 0; i < 64; i++)
        mem[i] = BW'({32'hC3A55A3C, 32'(i) * 32'h12345});
      for (int k = 0; k < RL; k++) rp[k] = '0;
    end

    assign widx  = 6'((baddr - BASE) >> SH);
    assign bdout = rp[RL-1];

    always @(posedge clk) begin
      if (ben) begin
        if (|bwe) mem[widx] <= bdin;
        rp[0] <= mem[widx];
      end
      for (int k = 1; k < RL; k++) rp[k] <= rp[k-1];
    end

    // Reference model: phase 0 idle, 1 launch, 2 run, 3 drain, 4 done.
    int            ph;
    logic          mdone;
    logic [31:0]   mcnt;
    logic [LW-1:0] mhold;
    int            due [$];
    logic [LW-1:0] dq  [$];

    always @(posedge clk) begin
      bit rd;
      if (rst) begin
        ph = 0; mdone = 0; mcnt = 0; mhold = '0;
        due.delete(); dq.delete();
      end else begin
        rd = cen[g] && (ph >= 1) && (ph <= 3) && !cwe[g];
        if (due.size() > 0 && due[0] == cyc) begin
          mhold = dq.pop_front();
          void'(due.pop_front());
        end
        if (rd) begin
          due.push_back(cyc + RL);
          dq.push_back(mem[cad[g][5:0]][LW-1:0]);
        end
        if (ph >= 1 && ph <= 3 && mcnt != 32'hFFFF_FFFF) mcnt++;
        if (ph == 0) begin
          if (st[g]) begin ph = 1; mcnt = 0; mdone = 0; end
        end else if (ph == 1) begin
          ph = 2;
        end else if (ph == 2) begin
          if (cd[g]) ph = 3;
        end else if (ph == 3) begin
          if (due.size() == 0) begin ph = 4; mdone = 1; end
        end else begin
          ph = 0;
        end
      end
    end

    always @(negedge clk) begin
      logic          eb, een, edv;
      logic [63:0]   ones;
      logic [LW-1:0] ed;
      if (chk_on) begin
        eb   = (ph >= 1) && (ph <= 3);
        een  = eb && cen[g];
        ones = (64'd1 << (BW / 8)) - 64'd1;
        edv  = (due.size() > 0) && (due[0] == cyc);
        ed   = edv ? dq[0] : mhold;
        chk($sformatf("i%0d busy", g), 64'(busy), 64'(eb));
        chk($sformatf("i%0d core_start", g), 64'(cs), 64'(ph == 1));
        chk($sformatf("i%0d done", g), 64'(done), 64'(mdone));
        chk($sformatf("i%0d count", g), 64'(cnt), 64'(mcnt));
        chk($sformatf("i%0d bram_en", g), 64'(ben), 64'(een));
        chk($sformatf("i%0d bram_we", g), 64'(bwe),
            (een && cwe[g]) ? ones : 64'd0);
        chk($sformatf("i%0d bram_addr", g), 64'(baddr),
            64'(BASE + (cad[g] << SH)));
        chk($sformatf("i%0d bram_din", g), 64'(bdin), 64'(cdi[g]));
        chk($sformatf("i%0d dout_valid", g), 64'(dv), 64'(edv));
        chk($sformatf("i%0d dout", g), 64'(dout), 64'(ed));
        chk($sformatf("i%0d bram_clk", g), 64'(bclk), 64'(clk));
        chk($sformatf("i%0d bram_rst", g), 64'(brst), 64'(rst));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    for (int i = 0; i < 2; i++) begin
      st[i] = 0; cd[i] = 0; cen[i] = 0; cwe[i] = 0;
      cad[i] = '0; cdi[i] = '0;
    end
  endtask

  initial begin
    rst = 1'b1;
    chk_on = 1'b0;
    idle_in();
    step(2);
    chk_on = 1'b1;
    #2;
    chk("reset busy", 64'(g_dut[0].busy), 64'd0);
    chk("reset done", 64'(g_dut[0].done), 64'd0);
    chk("reset valid", 64'(g_dut[1].dv), 64'd0);
    chk("reset count", 64'(g_dut[1].cnt), 64'd0);
    rst = 1'b0;

    // Start/completion: start at cycle 0, core_done at cycle 10.
    step(1); st[0] = 1;
    step(1); st[0] = 0;
    #2;
    chk("c1 core_start", 64'(g_dut[0].cs), 64'd1);
    chk("c1 busy", 64'(g_dut[0].busy), 64'd1);
    step(9); cd[0] = 1;
    step(1); cd[0] = 0;
    #2;
    chk("c11 busy", 64'(g_dut[0].busy), 64'd1);
    chk("c11 done", 64'(g_dut[0].done), 64'd0);
    step(1); #2;
    chk("c12 done", 64'(g_dut[0].done), 64'd1);
    chk("c12 busy", 64'(g_dut[0].busy), 64'd0);
    chk("c12 count", 64'(g_dut[0].cnt), 64'd11);
    step(1); #2;
    chk("c13 done sticky", 64'(g_dut[0].done), 64'd1);

    // Write in RUN, ignored done in LAUNCH, ignored restart, drain.
    step(1); st[0] = 1;
    step(1); st[0] = 0; cd[0] = 1;
    #2;
    chk("launch core_start", 64'(g_dut[0].cs), 64'd1);
    chk("start clears done", 64'(g_dut[0].done), 64'd0);
    step(1); cd[0] = 0;
    cen[0] = 1; cwe[0] = 1; cad[0] = 32'd7; cdi[0] = 17'h1FFFF;
    #2;
    chk("wr busy", 64'(g_dut[0].busy), 64'd1);
    chk("wr we", 64'(g_dut[0].bwe), 64'hF);
    chk("wr din", 64'(g_dut[0].bdin), 64'h0001_FFFF);
    chk("wr addr", 64'(g_dut[0].baddr), 64'h1C);
    step(1); cen[0] = 0; cwe[0] = 0; st[0] = 1;
    step(1); st[0] = 0; cen[0] = 1; cd[0] = 1;
    step(1); cen[0] = 0; cd[0] = 0;
    #2;
    chk("drain busy", 64'(g_dut[0].busy), 64'd1);
    chk("drain valid", 64'(g_dut[0].dv), 64'd1);
    chk("drain dout", 64'(g_dut[0].dout), 64'h1FFFF);
    chk("restart ignored count", 64'(g_dut[0].cnt), 64'd4);
    step(1); #2;
    chk("drain done", 64'(g_dut[0].done), 64'd1);
    chk("drain count", 64'(g_dut[0].cnt), 64'd5);
    step(1);
    cen[0] = 1; cwe[0] = 1; cad[0] = 32'd7; cdi[0] = 17'h1FFFF;
    #2;
    chk("idle en gated", 64'(g_dut[0].ben), 64'd0);
    chk("idle we gated", 64'(g_dut[0].bwe), 64'd0);
    step(1); idle_in();

    // Latency-2 reads of 3, 4, 5 on the 64-bit instance.
    step(1); st[1] = 1;
    step(1); st[1] = 0;
    step(1); cen[1] = 1; cad[1] = 32'd3;
    #2; chk("rd addr 3", 64'(g_dut[1].baddr), 64'h118);
    step(1); cad[1] = 32'd4;
    #2; chk("rd addr 4", 64'(g_dut[1].baddr), 64'h120);
    step(1); cad[1] = 32'd5; cd[1] = 1;
    #2;
    chk("rd addr 5", 64'(g_dut[1].baddr), 64'h128);
    chk("rd v0", 64'(g_dut[1].dv), 64'd1);
    chk("rd d0", 64'(g_dut[1].dout), 64'h169CF);
    step(1); cen[1] = 0; cd[1] = 0; cad[1] = '0;
    #2;
    chk("rd d1", 64'(g_dut[1].dout), 64'h08D14);
    chk("rd drain busy", 64'(g_dut[1].busy), 64'd1);
    step(1); #2;
    chk("rd v2", 64'(g_dut[1].dv), 64'd1);
    chk("rd d2", 64'(g_dut[1].dout), 64'h1B059);
    step(1); #2;
    chk("rd done", 64'(g_dut[1].done), 64'd1);
    chk("rd hold", 64'(g_dut[1].dout), 64'h1B059);
    chk("rd count", 64'(g_dut[1].cnt), 64'd6);

    // Reset mid-run with a read in flight; reset beats a start.
    step(1); st[1] = 1;
    step(1); st[1] = 0;
    step(1); cen[1] = 1; cad[1] = 32'd2;
    step(1); cen[1] = 0; rst = 1; st[0] = 1;
    step(1); rst = 0; st[0] = 0;
    #2;
    chk("abort busy", 64'(g_dut[1].busy), 64'd0);
    chk("abort done", 64'(g_dut[1].done), 64'd0);
    chk("abort valid", 64'(g_dut[1].dv), 64'd0);
    chk("abort count", 64'(g_dut[1].cnt), 64'd0);
    chk("abort dout", 64'(g_dut[1].dout), 64'd0);
    chk("rst beats start", 64'(g_dut[0].busy), 64'd0);
    chk("rst clears done", 64'(g_dut[0].done), 64'd0);
    step(1); #2;
    chk("abort no valid", 64'(g_dut[1].dv), 64'd0);
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
